ast_string_collector: RTL
=========================

AST_STRING_COLLECTOR -- requirements
Module: ast_string_collector

Interface
REQ-001 SHALL have parameters: BYTE_W, default BYTE_W (package), symbol width; AST_SINK_SYMBOLS, default 8, symbols per beat (>=1); AST_SINK_ORDER, default 1'b1, 1 = first symbol in high order bits; MAX_STR_SIZE, default MAX_STR_SIZE (package), longest accepted string in bytes.
REQ-002 SHALL derive AST_SINK_EMPTY_W = 1 if AST_SINK_SYMBOLS==1, else $clog2(AST_SINK_SYMBOLS); MAX_STR_SIZE_W = $clog2(MAX_STR_SIZE)+1.
REQ-003 SHALL have one clock, clk_i, input, 1; reset srst_i, input, 1: synchronous, active-high.
REQ-004 Avalon ST sink (readyLatency 0): ast_sink_data_i in [AST_SINK_SYMBOLS][BYTE_W]; ast_sink_ready_o out 1; ast_sink_valid_i in 1; ast_sink_empty_i in AST_SINK_EMPTY_W; ast_sink_endofpacket_i in 1; ast_sink_startofpacket_i in 1.
REQ-005 String output: str_data_o out [MAX_STR_SIZE][BYTE_W], byte 0 = first received; str_len_o out MAX_STR_SIZE_W; str_valid_o out 1; str_ready_i in 1.
REQ-006 Statistics: cnt_clean_stb_i in 1, clears counters; pkt_cnt_o out AMM_CSR_DATA_W, strings delivered; drop_cnt_o out AMM_CSR_DATA_W, packets discarded (REQ-019).

Function
REQ-007 FSM states SHALL be IDLE (await SOP), COLLECT (mid-packet), HOLD (string presented).
REQ-008 ast_sink_ready_o SHALL be 1 in IDLE and COLLECT, 0 in HOLD; a beat is accepted when valid_i && ready_o.
REQ-009 Within a beat, symbol k in arrival order SHALL be data[AST_SINK_SYMBOLS-1-k] if AST_SINK_ORDER=1, else data[k].
REQ-010 Valid symbols per beat SHALL be AST_SINK_SYMBOLS, minus empty_i on EOP beats only; empty_i SHALL be ignored on non-EOP beats.
REQ-011 Accepted bytes SHALL be written at byte offset len, len incremented by valid count; len SHALL saturate at MAX_STR_SIZE+1 (overflow flag).
REQ-012 IDLE + accepted SOP beat: clear buffer and len, write beat; EOP in same beat -> HOLD, else COLLECT.
REQ-013 IDLE + accepted non-SOP beat (orphan): SHALL be discarded; no state or counter change.
REQ-014 COLLECT + accepted SOP beat: partial string discarded, drop_cnt_o += 1, restart per REQ-012.
REQ-015 COLLECT + accepted EOP beat: if final len <= MAX_STR_SIZE -> HOLD; else discard, drop_cnt_o += 1, -> IDLE.
REQ-016 str_valid_o SHALL assert the cycle after the EOP beat is accepted and stay high with str_data_o/str_len_o stable until str_ready_i; on handshake -> IDLE, pkt_cnt_o += 1.
REQ-017 Bytes of str_data_o at offsets >= str_len_o SHALL be 0.
REQ-018 Counters SHALL saturate at all-ones; cnt_clean_stb_i clears both next cycle and wins over a simultaneous increment.
REQ-019 drop_cnt_o counts only oversize packets (REQ-015) and SOP-interrupted packets (REQ-014).

Reset
REQ-020 srst_i SHALL force IDLE, len 0, buffer 0, str_valid_o 0, str_len_o 0, both counters 0; ast_sink_ready_o is 1 the first cycle after reset release.
REQ-021 Reset during COLLECT or HOLD SHALL discard the partial/presented string without counting it.

Configuration
REQ-022 Macro AST_STRING_COLLECTOR_STATS_EN: when defined, counters function per REQ-006/018/019; when undefined, counter logic SHALL be omitted, pkt_cnt_o/drop_cnt_o tied to 0, cnt_clean_stb_i ignored; data path unchanged.

Structure
REQ-023 BYTE_W, MAX_STR_SIZE, AMM_CSR_DATA_W and the FSM state enum typedef SHALL live in bloom_filter_pkg.
REQ-024 Beat reordering and empty masking (REQ-009/010) SHALL be one combinational sub-module, ast_beat_unpack.

Verification (AST_SINK_SYMBOLS=4, MAX_STR_SIZE=16, ORDER=1, str_ready_i=1 unless noted)
REQ-025 SOP beat {A,B,C,D}, EOP beat {E,F,x,x} empty=2 -> str_len_o=6, bytes 0..5 = A..F, bytes 6..15 = 0, pkt_cnt_o=1.
REQ-026 20-byte packet (5 beats, empty=0) -> no str_valid_o, drop_cnt_o=1, ast_sink_ready_o stays 1.
REQ-027 str_ready_i low for 5 cycles after a string -> ast_sink_ready_o=0 and outputs stable for 5 cycles; pkt_cnt_o increments once on release.
REQ-028 SOP beat, then SOP+EOP beat {W,X,Y,Z} empty=0 -> drop_cnt_o=1, str_len_o=4 "WXYZ".
REQ-029 Orphan beat in IDLE, then srst_i during COLLECT -> no output, counters 0; next 1-beat packet delivered normally.
REQ-030 cnt_clean_stb_i concurrent with a string handshake -> pkt_cnt_o=0 next cycle.

Source files
------------

// File: rtl/bloom_filter_pkg.sv
// Shared widths and FSM state encoding for the string collector.
package bloom_filter_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned MAX_STR_SIZE   = 64;
  localparam int unsigned AMM_CSR_DATA_W = 32;

  typedef enum logic [1:0] {
    STATE_IDLE    = 2'd0,
    STATE_COLLECT = 2'd1,
    STATE_HOLD    = 2'd2
  } collector_state_e;

endpackage

// File: rtl/ast_beat_unpack.sv
// Reorders one Avalon-ST beat into arrival order and zeroes the empty symbols.
module ast_beat_unpack #(
  parameter int unsigned BYTE_W  = 8,
  parameter int unsigned SYMBOLS = 8,
  parameter logic        ORDER   = 1'b1,
  parameter int unsigned EMPTY_W = 3,
  parameter int unsigned CNT_W   = 4
) (
  input  logic [SYMBOLS-1:0][BYTE_W-1:0] data,
  input  logic [EMPTY_W-1:0]             empty,
  input  logic                           eop,
  output logic [SYMBOLS-1:0][BYTE_W-1:0] sym_c,
  output logic [CNT_W-1:0]               cnt_c
);

  int unsigned n_valid;

  // Empty only trims the tail of the last beat; oversized empty yields no symbols.
  always_comb begin
    n_valid = SYMBOLS;
    if (eop) begin
      n_valid = (32'(empty) >= SYMBOLS) ? 0 : SYMBOLS - 32'(empty);
    end
    cnt_c = CNT_W'(n_valid);
    for (int unsigned k = 0; k < SYMBOLS; k++) begin
      sym_c[k] = '0;
      if (k < n_valid) begin
        sym_c[k] = ORDER ? data[SYMBOLS-1-k] : data[k];
      end
    end
  end

endmodule

// File: rtl/ast_string_collector.sv
// Collects Avalon-ST packets into a flat byte string and presents it with valid/ready.
// Optional statistics counters are built when AST_STRING_COLLECTOR_STATS_EN is defined.
module ast_string_collector #(
  parameter int unsigned BYTE_W           = bloom_filter_pkg::BYTE_W,
  parameter int unsigned AST_SINK_SYMBOLS = 8,
  parameter logic        AST_SINK_ORDER   = 1'b1,
  parameter int unsigned MAX_STR_SIZE     = bloom_filter_pkg::MAX_STR_SIZE,
  localparam int unsigned AST_SINK_EMPTY_W = (AST_SINK_SYMBOLS == 1) ? 1 : $clog2(AST_SINK_SYMBOLS),
  localparam int unsigned MAX_STR_SIZE_W   = $clog2(MAX_STR_SIZE) + 1
) (
  input  logic                                        clk_i,
  input  logic                                        srst_i,

  input  logic [AST_SINK_SYMBOLS-1:0][BYTE_W-1:0]     ast_sink_data_i,
  output logic                                        ast_sink_ready_o,
  input  logic                                        ast_sink_valid_i,
  input  logic [AST_SINK_EMPTY_W-1:0]                 ast_sink_empty_i,
  input  logic                                        ast_sink_endofpacket_i,
  input  logic                                        ast_sink_startofpacket_i,

  output logic [MAX_STR_SIZE-1:0][BYTE_W-1:0]         str_data_o,
  output logic [MAX_STR_SIZE_W-1:0]                   str_len_o,
  output logic                                        str_valid_o,
  input  logic                                        str_ready_i,

  input  logic                                        cnt_clean_stb_i,
  output logic [bloom_filter_pkg::AMM_CSR_DATA_W-1:0] pkt_cnt_o,
  output logic [bloom_filter_pkg::AMM_CSR_DATA_W-1:0] drop_cnt_o
);

  import bloom_filter_pkg::*;

  localparam int unsigned CNT_W = $clog2(AST_SINK_SYMBOLS + 1);
  localparam int unsigned LEN_W = MAX_STR_SIZE_W;

  localparam logic [1:0] IDLE    = STATE_IDLE;
  localparam logic [1:0] COLLECT = STATE_COLLECT;
  localparam logic [1:0] HOLD    = STATE_HOLD;

  logic [1:0]                             state_q, state_d;
  logic [MAX_STR_SIZE-1:0][BYTE_W-1:0]    buf_q, buf_d, wr_buf;
  logic [LEN_W-1:0]                       len_q, len_d, wr_len;
  logic                                   ready_q, valid_q;
  logic                                   ready_d, valid_d;
  logic                                   accept, clr, fits;
  logic                                   pkt_inc, drop_inc;
  logic [AST_SINK_SYMBOLS-1:0][BYTE_W-1:0] beat_sym;
  logic [CNT_W-1:0]                       beat_cnt;

  assign accept = ast_sink_valid_i && ready_q;
  // A new packet always starts from an empty buffer.
  assign clr    = ast_sink_startofpacket_i || (state_q == IDLE);
  assign fits   = (wr_len <= LEN_W'(MAX_STR_SIZE));

  ast_beat_unpack #(
    .BYTE_W  (BYTE_W),
    .SYMBOLS (AST_SINK_SYMBOLS),
    .ORDER   (AST_SINK_ORDER),
    .EMPTY_W (AST_SINK_EMPTY_W),
    .CNT_W   (CNT_W)
  ) u_unpack (
    .data  (ast_sink_data_i),
    .empty (ast_sink_empty_i),
    .eop   (ast_sink_endofpacket_i),
    .sym_c (beat_sym),
    .cnt_c (beat_cnt)
  );

  // Buffer/length image after writing the current beat at the running offset.
  always_comb begin
    int unsigned base;
    int unsigned sum;
    base   = clr ? 0 : 32'(len_q);
    wr_buf = clr ? '0 : buf_q;
    for (int unsigned k = 0; k < AST_SINK_SYMBOLS; k++) begin
      if ((k < 32'(beat_cnt)) && ((base + k) < MAX_STR_SIZE)) begin
        wr_buf[base + k] = beat_sym[k];
      end
    end
    sum    = base + 32'(beat_cnt);
    wr_len = (sum > MAX_STR_SIZE + 1) ? LEN_W'(MAX_STR_SIZE + 1) : LEN_W'(sum);
  end

  // Next-state and datapath update; the buffer is wiped whenever the FSM returns to IDLE.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    len_d    = len_q;
    pkt_inc  = 1'b0;
    drop_inc = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        if (accept && (ast_sink_startofpacket_i || (state_q == COLLECT))) begin
          if ((state_q == COLLECT) && ast_sink_startofpacket_i) begin
            drop_inc = 1'b1;
          end
          buf_d   = wr_buf;
          len_d   = wr_len;
          state_d = COLLECT;
          if (ast_sink_endofpacket_i) begin
            if (fits) begin
              state_d = HOLD;
            end else begin
              drop_inc = 1'b1;
              buf_d    = '0;
              len_d    = '0;
              state_d  = IDLE;
            end
          end
        end
      end
      HOLD: begin
        if (str_ready_i) begin
          pkt_inc = 1'b1;
          buf_d   = '0;
          len_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        buf_d   = '0;
        len_d   = '0;
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d != HOLD);
    valid_d = (state_d == HOLD);
  end

  // State, buffer and handshake registers.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      buf_q   <= '0;
      len_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign ast_sink_ready_o = ready_q;
  assign str_valid_o      = valid_q;
  assign str_data_o       = buf_q;
  assign str_len_o        = len_q;

`ifdef AST_STRING_COLLECTOR_STATS_EN
  logic [AMM_CSR_DATA_W-1:0] pkt_cnt_q, drop_cnt_q;

  // Saturating counters; the clear strobe overrides a same-cycle increment.
  always_ff @(posedge clk_i) begin
    if (srst_i || cnt_clean_stb_i) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (pkt_inc && (pkt_cnt_q != '1)) begin
        pkt_cnt_q <= pkt_cnt_q + AMM_CSR_DATA_W'(1);
      end
      if (drop_inc && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + AMM_CSR_DATA_W'(1);
      end
    end
  end

  assign pkt_cnt_o  = pkt_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = ^{cnt_clean_stb_i, pkt_inc, drop_inc};
  assign pkt_cnt_o    = '0;
  assign drop_cnt_o   = '0;
`endif

endmodule
